sram_scanout_dma: RTL and testbench

//  Read-side master for the gfx SRAM primitive (1-cycle registered read, active-low i_WR_n/i_RD_n).
//  On a start pulse, streams LEN words from BASE through a small skid FIFO as a valid/ready pixel stream.

---
 rtl/sram_scanout_dma_pkg.sv | 14 +
 rtl/sram_scanout_dma_if.sv | 39 +++
 rtl/sram_scanout_dma_sync_fifo.sv | 40 ++++
 rtl/sram_scanout_dma.sv | 108 ++++++++++
 tb/tb_sram_scanout_dma.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_scanout_dma_pkg.sv
// Shared definitions for the SRAM scanout DMA: FSM encoding and default geometry.
package sram_scanout_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int DEF_DW         = 8;
    localparam int DEF_AW         = 10;
    localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/sram_scanout_dma_if.sv
// Bundles the control, host-write, SRAM and pixel-stream signals of the scanout DMA.
interface sram_scanout_dma_if #(
    parameter int DW = 8,
    parameter int AW = 10
) ();
    import sram_scanout_dma_pkg::*;

    logic          start;
    logic          abort;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic          hwr;
    logic [AW-1:0] haddr;
    logic [DW-1:0] hdin;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic          sram_wr_n;
    logic          sram_rd_n;
    logic [DW-1:0] sram_dout;
    // Pixel stream: a word moves on every clock where px_valid & px_ready are both high;
    // px_data holds steady while px_valid is high and px_ready is low.
    logic [DW-1:0] px_data;
    logic          px_valid;
    logic          px_ready;
    logic          busy;
    logic          done;
    state_t        dbg_state;

    modport master (
        input  start, abort, base, len, hwr, haddr, hdin, sram_dout, px_ready,
        output sram_addr, sram_din, sram_wr_n, sram_rd_n, px_data, px_valid, busy, done, dbg_state
    );

    modport slave (
        output start, abort, base, len, hwr, haddr, hdin, sram_dout, px_ready,
        input  sram_addr, sram_din, sram_wr_n, sram_rd_n, px_data, px_valid, busy, done, dbg_state
    );

endinterface

// File: rtl/sram_scanout_dma_sync_fifo.sv
// Small synchronous FIFO with occupancy count and synchronous clear; head is shown combinationally.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/sram_scanout_dma.sv
// Scanout read master for a 1-cycle registered SRAM: streams LEN words from BASE through a
// skid FIFO, while host writes take the SRAM port whenever they are strobed.
module sram_scanout_dma
    import sram_scanout_dma_pkg::*;
#(
    parameter int DW         = DEF_DW,
    parameter int AW         = DEF_AW,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic clk,
    input  logic rst,
    sram_scanout_dma_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t        state_q, state_d;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   remaining;
    logic          inflight;
    logic          done_q;
    logic [CW-1:0] fifo_count;
    logic [DW-1:0] fifo_head;
    logic [CW:0]   credit_used;
    logic          start_ok, credit_ok, issue, push, pop, last_pop, px_valid;

    assign start_ok    = bus.start && !bus.abort && (state_q == ST_IDLE);
    // Reads already in flight count against FIFO space so a capture never meets a full FIFO.
    assign credit_used = {1'b0, fifo_count} + (CW+1)'(inflight);
    assign credit_ok   = credit_used < (CW+1)'(FIFO_DEPTH);
    assign issue       = !rst && !bus.abort && !bus.hwr && (state_q == ST_RUN) && credit_ok;
    assign push        = inflight && !bus.abort;
    assign px_valid    = (fifo_count != '0);
    assign pop         = px_valid && bus.px_ready;
    assign last_pop    = (state_q == ST_DRAIN) && !inflight && (fifo_count == CW'(1)) && pop;

    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start_ok && (bus.len != '0)) state_d = ST_RUN;
                ST_RUN:   if (issue && (remaining == (AW+1)'(1))) state_d = ST_DRAIN;
                ST_DRAIN: if (last_pop) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rd_ptr    <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            inflight <= issue;
            done_q   <= !bus.abort && ((start_ok && (bus.len == '0)) || last_pop);
            if (start_ok) begin
                rd_ptr    <= bus.base;
                remaining <= bus.len;
            end else if (issue) begin
                rd_ptr    <= rd_ptr + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end

    // Host writes own the port in their cycle; reads only go out when no write is strobed.
    always_comb begin
        bus.sram_addr = '0;
        bus.sram_din  = '0;
        bus.sram_wr_n = 1'b1;
        bus.sram_rd_n = 1'b1;
        if (!rst && bus.hwr) begin
            bus.sram_wr_n = 1'b0;
            bus.sram_addr = bus.haddr;
            bus.sram_din  = bus.hdin;
        end else if (issue) begin
            bus.sram_rd_n = 1'b0;
            bus.sram_addr = rd_ptr;
        end
    end

    sync_fifo #(
        .W     (DW),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.abort),
        .push  (push),
        .din   (bus.sram_dout),
        .pop   (pop),
        .dout  (fifo_head),
        .count (fifo_count)
    );

    assign bus.px_valid  = px_valid;
    assign bus.px_data   = px_valid ? fifo_head : '0;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_sram_scanout_dma.sv
// Bench for sram_scanout_dma with a behavioural 1-cycle SRAM preloaded RAM[a] = a[7:0].
module tb_sram_scanout_dma;
    import sram_scanout_dma_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 10;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_scanout_dma_if #(.DW(DW), .AW(AW)) bus ();

    sram_scanout_dma #(.DW(DW), .AW(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // SRAM model: registered read, write on WR_n low
    logic [7:0] mem [1024];
    always @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < 1024; a++) mem[a] <= a[7:0];
        end else if (!bus.sram_wr_n) begin
            mem[bus.sram_addr] <= bus.sram_din;
        end
        if (!bus.sram_rd_n) bus.sram_dout <= mem[bus.sram_addr];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard and monitor
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_word;
    int xfer_cnt = 0;
    int done_cnt = 0;
    int rd_cnt   = 0;
    int occ      = 0;
    logic prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.px_valid && bus.px_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL px_unexpected: got %0h expected no word", bus.px_data);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("px_data", bus.px_data, exp_word);
                end
                xfer_cnt++;
            end
            if (prev_hold && bus.px_valid) check("px_hold", bus.px_data, prev_data);
            prev_hold = bus.px_valid && !bus.px_ready;
            prev_data = bus.px_data;
            if (bus.done) done_cnt++;
            if (!bus.sram_rd_n) begin
                check("rd_credit", occ < DEPTH, 1);
                rd_cnt++;
            end
            occ = occ + (!bus.sram_rd_n ? 1 : 0) - ((bus.px_valid && bus.px_ready) ? 1 : 0);
            if (bus.abort) occ = 0;
        end
    end

    // Ready generator: 0 = held high, 1 = high one cycle in three, 2 = held low
    int ready_mode = 0;
    int cyc = 0;
    initial begin
        bus.px_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            case (ready_mode)
                0:       bus.px_ready = 1'b1;
                1:       bus.px_ready = (cyc % 3 == 0);
                default: bus.px_ready = 1'b0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_scan(input logic [AW-1:0] b, input logic [AW:0] l);
        bus.base  = b;
        bus.len   = l;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic expect_words(input logic [AW-1:0] b, input int l);
        logic [AW-1:0] a;
        for (int i = 0; i < l; i++) begin
            a = b + AW'(i);
            exp_q.push_back(a[7:0]);
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check({name, "_done_once"}, done_cnt - d0, 1);
        check({name, "_busy_after"}, bus.busy, 0);
        check({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0, r0, d0, n;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.base  = '0;
        bus.len   = '0;
        bus.hwr   = 1'b0;
        bus.haddr = '0;
        bus.hdin  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wr_n", bus.sram_wr_n, 1);
        check("rst_rd_n", bus.sram_rd_n, 1);
        check("rst_addr", bus.sram_addr, 0);
        check("rst_din", bus.sram_din, 0);
        check("rst_valid", bus.px_valid, 0);
        check("rst_data", bus.px_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_state", bus.dbg_state, ST_IDLE);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Back-to-back scan with first-valid latency
        ready_mode = 0;
        tick();
        expect_words(10'h010, 16);
        x0 = xfer_cnt;
        r0 = rd_cnt;
        start_scan(10'h010, 11'd16);
        check("t1_busy", bus.busy, 1);
        @(negedge clk);
        check("t1_valid_n0", bus.px_valid, 0);
        @(negedge clk);
        check("t1_valid_n1", bus.px_valid, 0);
        @(negedge clk);
        check("t1_valid_n2", bus.px_valid, 1);
        tick();
        repeat (15) tick();
        check("t1_throughput", xfer_cnt - x0, 16);
        wait_done("t1", 100);
        check("t1_rd_issues", rd_cnt - r0, 16);

        // Address wrap
        exp_q.push_back(8'hFE);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        start_scan(10'h3FE, 11'd4);
        wait_done("t2", 100);

        // Throttled ready
        ready_mode = 1;
        expect_words(10'h120, 32);
        start_scan(10'h120, 11'd32);
        wait_done("t3", 400);
        ready_mode = 0;
        tick();

        // Host writes every other cycle during a scan, then read them back
        expect_words(10'h0A0, 8);
        start_scan(10'h0A0, 11'd8);
        for (int k = 0; k < 16; k++) begin
            if (k % 2 == 0) begin
                bus.hwr   = 1'b1;
                bus.haddr = 10'h200 + AW'(k / 2);
                bus.hdin  = 8'h50 + DW'(k / 2);
                @(negedge clk);
                check("hw_wr_n", bus.sram_wr_n, 0);
                check("hw_rd_n", bus.sram_rd_n, 1);
                check("hw_addr", bus.sram_addr, 10'h200 + AW'(k / 2));
                check("hw_din", bus.sram_din, 8'h50 + DW'(k / 2));
                tick();
            end else begin
                bus.hwr = 1'b0;
                tick();
            end
        end
        bus.hwr = 1'b0;
        wait_done("t4", 100);
        for (int k = 0; k < 8; k++) exp_q.push_back(8'h50 + DW'(k));
        start_scan(10'h200, 11'd8);
        wait_done("t4_readback", 100);

        // Abort after five transfers, then a fresh short scan
        expect_words(10'h040, 20);
        x0 = xfer_cnt;
        start_scan(10'h040, 11'd20);
        n = 0;
        while (xfer_cnt - x0 < 5 && n < 100) begin
            tick();
            n++;
        end
        check("ab_xfers", xfer_cnt - x0, 5);
        d0 = done_cnt;
        bus.abort  = 1'b1;
        ready_mode = 2;
        tick();
        bus.abort = 1'b0;
        @(negedge clk);
        check("ab_valid", bus.px_valid, 0);
        check("ab_busy", bus.busy, 0);
        check("ab_state", bus.dbg_state, ST_IDLE);
        exp_q.delete();
        tick();
        repeat (5) tick();
        check("ab_no_done", done_cnt - d0, 0);
        check("ab_no_data", bus.px_valid, 0);
        ready_mode = 0;
        tick();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        start_scan(10'h000, 11'd2);
        wait_done("t5", 100);

        // Zero-length start
        d0 = done_cnt;
        r0 = rd_cnt;
        start_scan(10'h055, 11'd0);
        check("len0_busy", bus.busy, 0);
        @(negedge clk);
        check("len0_done", bus.done, 1);
        tick();
        repeat (3) tick();
        check("len0_done_count", done_cnt - d0, 1);
        check("len0_no_reads", rd_cnt - r0, 0);
        check("len0_busy_after", bus.busy, 0);

        // Start while busy is ignored
        expect_words(10'h080, 8);
        start_scan(10'h080, 11'd8);
        tick();
        check("sb_busy", bus.busy, 1);
        start_scan(10'h300, 11'd3);
        wait_done("t6", 100);

        check("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
